pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register that replaces the fixed-field, halt-only inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. Each stage carries a `WIDTH`-bit packed payload with a valid bit and a valid/ready handshake. It has an optional one-entry skid buffer so `ready_o` can be registered. It supports halt (freeze) and flush (bubble insertion), and flush loads a programmable NOP payload.

---
 rtl/pipe_stage_reg_pkg.sv | 23 ++
 rtl/pipe_stage_reg_if.sv | 36 +++
 rtl/pipe_stage_reg.sv | 101 ++++++++++
 tb/tb_pipe_stage_reg.sv | 137 +++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the generic pipeline stage register.
//   pipe_state_t : stage occupancy state (EMPTY / FULL / SKID)
//   PIPE_OCC_W   : width of the occupancy count output
package pipe_pkg;

  localparam int PIPE_OCC_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_t;

  // Occupancy count for a given state.
  function automatic logic [PIPE_OCC_W-1:0] pipe_occ(pipe_state_t s);
    case (s)
      FULL:    return 2'd1;
      SKID:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake/payload bundle between a producer, a pipe_stage_reg and its consumer.
// Signal names are from the stage's point of view:
//   valid_i/data_i  : upstream payload into the stage
//   ready_o         : stage can accept
//   valid_o/data_o  : payload out of the stage
//   ready_i         : downstream accepts
//   halt_i/flush_i  : freeze / discard controls
//   occupancy_o     : held entry count (0..2)
// slave  : the stage side
// master : the driver side (producer + consumer + control)
interface pipe_stage_reg_if #(
  parameter int WIDTH = 32
) ();
  import pipe_pkg::*;

  logic                  valid_i;
  logic                  ready_o;
  logic [WIDTH-1:0]      data_i;
  logic                  valid_o;
  logic                  ready_i;
  logic [WIDTH-1:0]      data_o;
  logic                  halt_i;
  logic                  flush_i;
  logic [PIPE_OCC_W-1:0] occupancy_o;

  modport slave (
    input  valid_i, data_i, ready_i, halt_i, flush_i,
    output ready_o, valid_o, data_o, occupancy_o
  );

  modport master (
    output valid_i, data_i, ready_i, halt_i, flush_i,
    input  ready_o, valid_o, data_o, occupancy_o
  );

endinterface

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, halt (freeze),
// flush (bubble insertion with programmable NOP payload) and an optional
// one-entry skid buffer that lets ready_o come from a register.
// Ports:
//   clk_i : clock, all state on rising edge
//   rst_i : synchronous active-high reset
//   bus   : pipe_stage_reg_if.slave handshake/payload/control bundle
// Parameters:
//   WIDTH     : payload width
//   SKID_EN   : 1 = skid entry + registered ready, 0 = single entry, comb ready
//   NOP_VALUE : payload loaded on reset and flush
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter bit               SKID_EN   = 1'b1,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
  input logic             clk_i,
  input logic             rst_i,
  pipe_stage_reg_if.slave bus
);

  pipe_state_t      r_state, w_state_nxt;
  logic [WIDTH-1:0] r_main,  w_main_nxt;
  logic [WIDTH-1:0] r_skid,  w_skid_nxt;

  logic w_valid, w_ready, w_in_fire, w_out_fire;

  assign w_valid = (r_state != EMPTY);

  // With the skid entry, ready depends only on registered state plus halt,
  // so there is no ready_i -> ready_o path.
  generate
    if (SKID_EN) begin : g_skid_rdy
      assign w_ready = (r_state != SKID) & ~bus.halt_i;
    end else begin : g_comb_rdy
      assign w_ready = (~w_valid | bus.ready_i) & ~bus.halt_i;
    end
  endgenerate

  assign w_in_fire  = bus.valid_i & w_ready;
  assign w_out_fire = w_valid & bus.ready_i & ~bus.halt_i;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (bus.flush_i) begin
      w_state_nxt = EMPTY;
      w_main_nxt  = NOP_VALUE;
      w_skid_nxt  = NOP_VALUE;
    end else if (!bus.halt_i) begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            w_main_nxt  = bus.data_i;
            w_state_nxt = FULL;
          end
        end
        FULL: begin
          if (w_in_fire && w_out_fire) begin
            w_main_nxt = bus.data_i;
          end else if (w_in_fire && SKID_EN) begin
            // Downstream stalled after ready_o was already promised: park it.
            w_skid_nxt  = bus.data_i;
            w_state_nxt = SKID;
          end else if (w_out_fire) begin
            // data_o intentionally keeps its last value while empty.
            w_state_nxt = EMPTY;
          end
        end
        SKID: begin
          if (w_out_fire) begin
            w_main_nxt  = r_skid;
            w_state_nxt = FULL;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= EMPTY;
      r_main  <= NOP_VALUE;
      r_skid  <= NOP_VALUE;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  assign bus.ready_o     = w_ready;
  assign bus.valid_o     = w_valid;
  assign bus.data_o      = r_main;
  assign bus.occupancy_o = pipe_occ(r_state);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: DUT A (SKID_EN=1, NOP=0x13) runs the main scenarios,
// DUT B (SKID_EN=0, NOP=0) checks the combinational-ready variant.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.WIDTH(32)) ifa ();
  pipe_stage_reg_if #(.WIDTH(32)) ifb ();

  pipe_stage_reg #(.WIDTH(32), .SKID_EN(1'b1), .NOP_VALUE(32'h13)) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(ifa.slave)
  );
  pipe_stage_reg #(.WIDTH(32), .SKID_EN(1'b0), .NOP_VALUE(32'h0)) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(ifb.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    ifa.valid_i = 0; ifa.data_i = '0; ifa.ready_i = 1; ifa.halt_i = 0; ifa.flush_i = 0;
    ifb.valid_i = 0; ifb.data_i = '0; ifb.ready_i = 1; ifb.halt_i = 0; ifb.flush_i = 0;

    // Reset
    tick(); tick();
    chk("rst_valid", 32'(ifa.valid_o), 32'd0);
    chk("rst_occ",   32'(ifa.occupancy_o), 32'd0);
    chk("rst_data",  ifa.data_o, 32'h13);
    chk("rstb_data", ifb.data_o, 32'h0);
    rst = 1'b0; #1;
    chk("rst_ready", 32'(ifa.ready_o), 32'd1);

    // Streaming
    ifa.valid_i = 1; ifa.data_i = 32'h1; tick();
    chk("s1_data", ifa.data_o, 32'h1);
    chk("s1_valid", 32'(ifa.valid_o), 32'd1);
    chk("s1_occ", 32'(ifa.occupancy_o), 32'd1);
    ifa.data_i = 32'h2; tick();
    chk("s2_data", ifa.data_o, 32'h2);
    chk("s2_occ", 32'(ifa.occupancy_o), 32'd1);
    ifa.data_i = 32'h3; tick();
    chk("s3_data", ifa.data_o, 32'h3);
    chk("s3_valid", 32'(ifa.valid_o), 32'd1);
    ifa.valid_i = 0; tick();
    chk("drain_valid", 32'(ifa.valid_o), 32'd0);
    chk("drain_data", ifa.data_o, 32'h3);
    chk("drain_occ", 32'(ifa.occupancy_o), 32'd0);

    // Backpressure into skid
    ifa.valid_i = 1; ifa.data_i = 32'hA; tick();
    chk("bp_a", ifa.data_o, 32'hA);
    ifa.ready_i = 0; ifa.data_i = 32'hB; tick();
    chk("bp_occ2", 32'(ifa.occupancy_o), 32'd2);
    chk("bp_ready0", 32'(ifa.ready_o), 32'd0);
    chk("bp_hold_a", ifa.data_o, 32'hA);
    ifa.valid_i = 0; ifa.ready_i = 1; #1;
    chk("bp_ready_reg", 32'(ifa.ready_o), 32'd0);
    tick();
    chk("bp_b", ifa.data_o, 32'hB);
    chk("bp_occ1", 32'(ifa.occupancy_o), 32'd1);
    tick();
    chk("bp_empty", 32'(ifa.valid_o), 32'd0);

    // Halt
    ifa.valid_i = 1; ifa.data_i = 32'h55; tick();
    chk("h_load", ifa.data_o, 32'h55);
    ifa.halt_i = 1; ifa.data_i = 32'h66; #1;
    chk("h_ready0", 32'(ifa.ready_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("h_data", ifa.data_o, 32'h55);
      chk("h_occ", 32'(ifa.occupancy_o), 32'd1);
    end
    ifa.halt_i = 0; #1;
    chk("h_ready1", 32'(ifa.ready_o), 32'd1);
    tick();
    chk("h_next", ifa.data_o, 32'h66);

    // Flush + halt from SKID
    ifa.ready_i = 0; ifa.data_i = 32'h77; tick();
    chk("f_occ2", 32'(ifa.occupancy_o), 32'd2);
    ifa.flush_i = 1; ifa.halt_i = 1; ifa.data_i = 32'h88; tick();
    chk("f_valid", 32'(ifa.valid_o), 32'd0);
    chk("f_occ", 32'(ifa.occupancy_o), 32'd0);
    chk("f_data", ifa.data_o, 32'h13);
    tick();
    chk("f_hold_occ", 32'(ifa.occupancy_o), 32'd0);
    ifa.flush_i = 0; ifa.halt_i = 0; ifa.valid_i = 0; #1;
    chk("f_ready", 32'(ifa.ready_o), 32'd1);

    // Reset from SKID
    ifa.valid_i = 1; ifa.data_i = 32'h91; tick();
    ifa.data_i = 32'h92; tick();
    chk("r_occ2", 32'(ifa.occupancy_o), 32'd2);
    rst = 1; tick();
    rst = 0; ifa.valid_i = 0; #1;
    chk("r_valid", 32'(ifa.valid_o), 32'd0);
    chk("r_data", ifa.data_o, 32'h13);
    chk("r_ready", 32'(ifa.ready_o), 32'd1);
    chk("r_occ", 32'(ifa.occupancy_o), 32'd0);

    // SKID_EN=0: combinational ready
    ifb.valid_i = 1; ifb.data_i = 32'h21; ifb.ready_i = 1; tick();
    chk("b_load", ifb.data_o, 32'h21);
    ifb.ready_i = 0; ifb.data_i = 32'h22; #1;
    chk("b_ready0", 32'(ifb.ready_o), 32'd0);
    tick();
    chk("b_occ", 32'(ifb.occupancy_o), 32'd1);
    chk("b_hold", ifb.data_o, 32'h21);
    ifb.ready_i = 1; #1;
    chk("b_ready1", 32'(ifb.ready_o), 32'd1);
    tick();
    chk("b_next", ifb.data_o, 32'h22);
    chk("b_occ1", 32'(ifb.occupancy_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
